// File: rtl/watchdog_pkg.sv
// Shared types and constants for the watchdog datapath: sequencer states,
// result error codes and the legal eigenvalue-core regime encodings.
package watchdog_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, WAIT, HOLD} eig_sched_state_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_REGIME  = 2'b10;

  localparam logic [2:0] REG_UNDER = 3'b001;
  localparam logic [2:0] REG_CRIT  = 3'b010;
  localparam logic [2:0] REG_OVER  = 3'b100;

  function automatic logic regime_ok(input logic [2:0] r);
    return (r == REG_UNDER) || (r == REG_CRIT) || (r == REG_OVER);
  endfunction
endpackage

// File: rtl/wd_sat_cnt.sv
// Saturating up-counter with increment enable; sticks at all-ones.
module wd_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  count <= '0;
    else if (inc && count != '1) count <= count + W'(1);
  end
endmodule

// File: rtl/eig_sched.sv
// Request-side sequencer for the eigenvalue core: issue a pair, wait out the
// core latency under a watchdog, and hand the (possibly flagged) result on.
module eig_sched
  import watchdog_pkg::*;
#(
  parameter int MIN_LAT = 4,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [31:0] in_a0,
  input  logic signed [31:0] in_a1,
  output logic               data_rdy,
  output logic signed [31:0] a0,
  output logic signed [31:0] a1,
  input  logic               core_busy,
  input  logic signed [31:0] kappa,
  input  logic signed [31:0] inv_kappa,
  input  logic [2:0]         regime,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [31:0] out_kappa,
  output logic signed [31:0] out_inv_kappa,
  output logic [2:0]         out_regime,
  output logic [1:0]         out_err,
  output logic [CNT_W-1:0]   err_count
);
  localparam int MAXC = (MIN_LAT > TIMEOUT) ? MIN_LAT : TIMEOUT;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] SETTLE_END = CW'(MIN_LAT - 1);
  localparam logic [CW-1:0] WAIT_END   = CW'(TIMEOUT - 1);

  eig_sched_state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic take, cap, tmo, err_inc;

  assign in_ready  = (state == IDLE);
  assign data_rdy  = (state == ISSUE);
  assign out_valid = (state == HOLD);
  assign take      = in_ready & in_valid;
  // An idle core wins over the timeout on the final WAIT cycle.
  assign cap       = (state == WAIT) & ~core_busy;
  assign tmo       = (state == WAIT) & core_busy & (cnt == WAIT_END);
  assign err_inc   = (cap & ~regime_ok(regime)) | tmo;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = ISSUE;
      ISSUE:   state_nxt = SETTLE;
      SETTLE:  if (cnt == SETTLE_END) state_nxt = WAIT;
      WAIT:    if (cap || tmo) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      case (state)
        SETTLE:  cnt <= (cnt == SETTLE_END) ? '0 : cnt + CW'(1);
        WAIT:    if (core_busy && !tmo) cnt <= cnt + CW'(1);
        default: cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a0 <= '0;
      a1 <= '0;
    end else if (take) begin
      a0 <= in_a0;
      a1 <= in_a1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_kappa     <= '0;
      out_inv_kappa <= '0;
      out_regime    <= '0;
      out_err       <= ERR_OK;
    end else if (cap) begin
      out_kappa     <= kappa;
      out_inv_kappa <= inv_kappa;
      out_regime    <= regime;
      out_err       <= regime_ok(regime) ? ERR_OK : ERR_REGIME;
    end else if (tmo) begin
      out_kappa     <= '0;
      out_inv_kappa <= '0;
      out_regime    <= '0;
      out_err       <= ERR_TIMEOUT;
    end
  end

  wd_sat_cnt #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_inc),
    .count (err_count)
  );
endmodule

// File: tb/tb_eig_sched.sv
// Randomized bench for eig_sched against a cycle-offset reference model of
// issue, settle, watchdog wait and result hold.
module tb_eig_sched;
  localparam int MIN_LAT = 4;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 2;
  localparam int W0      = MIN_LAT + 2;

  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, data_rdy, core_busy = 0, out_valid, out_ready = 0;
  logic signed [31:0] in_a0 = 0, in_a1 = 0, a0, a1, kappa = 0, inv_kappa = 0;
  logic signed [31:0] out_kappa, out_inv_kappa;
  logic [2:0] regime = 0, out_regime;
  logic [1:0] out_err;
  logic [CNT_W-1:0] err_count;

  int total = 0, bad = 0;
  int exp_err = 0;

  eig_sched #(.MIN_LAT(MIN_LAT), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a0(in_a0), .in_a1(in_a1), .data_rdy(data_rdy), .a0(a0), .a1(a1),
    .core_busy(core_busy), .kappa(kappa), .inv_kappa(inv_kappa), .regime(regime),
    .out_valid(out_valid), .out_ready(out_ready), .out_kappa(out_kappa),
    .out_inv_kappa(out_inv_kappa), .out_regime(out_regime), .out_err(out_err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Core busy in cycles 1..lat after the handshake, low afterwards.
  task automatic run_txn(input logic [31:0] va0, input logic [31:0] va1,
                         input logic [31:0] kap, input logic [31:0] ikap,
                         input logic [2:0] rg, input int lat, input int hold);
    int v, c, expv;
    logic [31:0] ek, eik;
    logic [2:0] er;
    logic [1:0] ee;
    c = (lat + 1 > W0) ? lat + 1 : W0;
    if (c <= W0 + TIMEOUT - 1) begin
      expv = c + 1; ek = kap; eik = ikap; er = rg;
      ee = (rg == 3'b001 || rg == 3'b010 || rg == 3'b100) ? 2'b00 : 2'b10;
    end else begin
      expv = W0 + TIMEOUT; ek = 0; eik = 0; er = 0; ee = 2'b01;
    end

    @(posedge clk); #1;
    in_valid = 1; in_a0 = va0; in_a1 = va1;
    kappa = kap; inv_kappa = ikap; regime = rg; core_busy = 0;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    v = -1;
    for (int k = 1; k <= W0 + TIMEOUT + 8 && v < 0; k++) begin
      @(posedge clk); #1;
      in_valid = 0; core_busy = (k <= lat);
      @(negedge clk);
      chk("data_rdy", data_rdy, (k == 1));
      chk("in_ready_busy", in_ready, 0);
      chk("a0", a0, va0);
      chk("a1", a1, va1);
      if (out_valid) v = k;
    end
    chk("latency", v, expv);
    if (v < 0) begin
      out_ready = 1; @(posedge clk); #1; out_ready = 0;
      return;
    end
    if (ee != 0 && exp_err < (1 << CNT_W) - 1) exp_err++;
    chk("out_kappa", out_kappa, ek);
    chk("out_inv_kappa", out_inv_kappa, eik);
    chk("out_regime", out_regime, er);
    chk("out_err", out_err, ee);
    chk("err_count", err_count, exp_err);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      in_valid = $urandom_range(0, 1); in_a0 = $urandom; core_busy = $urandom_range(0, 1);
      kappa = $urandom; regime = 3'($urandom);
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_kappa", out_kappa, ek);
      chk("hold_inv_kappa", out_inv_kappa, eik);
      chk("hold_err", out_err, ee);
      chk("hold_a0", a0, va0);
      chk("hold_errcnt", err_count, exp_err);
    end
    @(posedge clk); #1;
    in_valid = 0; out_ready = 1; core_busy = 0;
    @(posedge clk); #1;
    out_ready = 0;
    @(negedge clk);
    chk("released_valid", out_valid, 0);
    chk("released_ready", in_ready, 1);
  endtask

  function automatic logic [2:0] rand_regime();
    logic [2:0] r;
    r = 3'($urandom_range(0, 7));
    if ($urandom_range(0, 2) != 0) r = 3'(1 << $urandom_range(0, 2));
    return r;
  endfunction

  initial begin
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_data_rdy", data_rdy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_out_kappa", out_kappa, 0);
    chk("rst_out_inv", out_inv_kappa, 0);
    chk("rst_out_regime", out_regime, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_a0", a0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    run_txn(32'h0001_0000, 32'h0000_8000, 32'h0000_4000, 32'h0004_0000, 3'b001, 10, 1);
    run_txn(32'h1234_5678, 32'h8765_4321, 32'h0000_0042, 32'h0000_0024, 3'b100, 0, 1);
    run_txn(32'h0000_0001, 32'h0000_0002, 32'h1111_1111, 32'h2222_2222, 3'b010, 1000, 1);
    run_txn(32'h0000_0003, 32'h0000_0004, 32'h0000_1234, 32'h0000_5678, 3'b011, 3, 1);
    repeat (3) run_txn($urandom, $urandom, $urandom, $urandom, 3'b001, 1000, 0);
    chk("err_saturated", err_count, 3);

    for (int i = 0; i < 20; i++)
      run_txn($urandom, $urandom, $urandom, $urandom, rand_regime(),
              $urandom_range(0, 25), $urandom_range(0, 3));

    run_txn(32'h0000_0aaa, 32'h0000_0bbb, 32'h0000_0ccc, 32'h0000_0ddd, 3'b010, 8, 20);

    // Mid-operation reset during SETTLE of the next pair.
    @(posedge clk); #1 in_valid = 1; in_a0 = 32'h5555_0000; core_busy = 0;
    @(posedge clk); #1 in_valid = 0; core_busy = 1;
    @(posedge clk); #1;
    @(posedge clk); #2 rst_n = 0;
    #1;
    chk("mid_rst_data_rdy", data_rdy, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_err_count", err_count, 0);
    @(posedge clk); #1 rst_n = 1; core_busy = 0; exp_err = 0;
    for (int k = 0; k < W0 + TIMEOUT + 4; k++) begin
      @(negedge clk);
      chk("post_rst_no_result", out_valid, 0);
      chk("post_rst_no_issue", data_rdy, 0);
    end
    run_txn(32'h0000_0777, 32'h0000_0888, 32'h0000_0999, 32'h0000_0111, 3'b111, 5, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog sim time limit reached");
    $fatal(1);
  end
endmodule
